// File: rtl/dphy_lp_tx_seq_pkg.sv
// Shared D-PHY LP definitions: sequencer state encoding, LP line codes, escape command bytes.
// Also used by the LP-RX escape decoder.
package dphy_pkg;

  typedef enum logic [3:0] {
    ST_STOP      = 4'd0,
    ST_HS_RQST   = 4'd1,
    ST_HS_PRPR   = 4'd2,
    ST_HS_GO     = 4'd3,
    ST_HS_EXIT   = 4'd4,
    ST_ESC_RQST  = 4'd5,
    ST_ESC_BRDG  = 4'd6,
    ST_ESC_ENTRY = 4'd7,
    ST_ESC_GO    = 4'd8,
    ST_ESC_MARK  = 4'd9,
    ST_ESC_SPACE = 4'd10,
    ST_ULPS      = 4'd11,
    ST_WAKE      = 4'd12
  } lp_state_t;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam logic [7:0] ESC_CMD_ULPS = 8'h1E;

  function automatic int max_cyc(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dphy_lp_tx_seq_if.sv
// PPI-side request/status bundle between the upper layer (master) and the LP-TX sequencer (slave).
// Requests are levels; all status outputs come straight from sequencer registers.
interface dphy_lp_tx_seq_if;
  logic LPTX_EN;
  logic TxRequestHS;
  logic TxRequestEsc;
  logic TxUlpsEsc;
  logic TxUlpsExit;
  logic Dp;
  logic Dn;
  logic LP_OE;
  logic HSTX_EN;
  logic HSCLK_EN;
  logic Stopstate;
  logic UlpsActiveNot;

  modport master (
    output LPTX_EN, TxRequestHS, TxRequestEsc, TxUlpsEsc, TxUlpsExit,
    input  Dp, Dn, LP_OE, HSTX_EN, HSCLK_EN, Stopstate, UlpsActiveNot
  );

  modport slave (
    input  LPTX_EN, TxRequestHS, TxRequestEsc, TxUlpsEsc, TxUlpsExit,
    output Dp, Dn, LP_OE, HSTX_EN, HSCLK_EN, Stopstate, UlpsActiveNot
  );
endinterface

// File: rtl/dphy_lp_timer.sv
// LP state duration timer: counts from 0 after clr, expire is high on the last cycle (cnt == limit-1).
// Combinational expire, no backpressure.
module dphy_lp_timer #(
  parameter int TMR_W = 5
) (
  input  logic             LPTX_CLK,
  input  logic             TxRSt,
  input  logic             clr,
  input  logic [TMR_W-1:0] limit,
  output logic             expire
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge LPTX_CLK or negedge TxRSt) begin
    if (!TxRSt) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expire = (cnt == (limit - TMR_W'(1)));

endmodule

// File: rtl/dphy_lp_tx_seq.sv
// D-PHY data-lane LP-TX sequencer: HS entry/exit, escape entry + command, ULPS and wake-up.
// Request sampled at edge k drives the new LP code after edge k; all outputs registered, no backpressure.
module dphy_lp_tx_seq #(
  parameter int          LPX_CYC    = 4,
  parameter int          HSPREP_CYC = 6,
  parameter int          HSEXIT_CYC = 5,
  parameter int          WAKEUP_CYC = 10,
  parameter logic [7:0]  ESC_CMD    = dphy_pkg::ESC_CMD_ULPS,
  parameter int          TMR_W      = $clog2(dphy_pkg::max_cyc(LPX_CYC, HSPREP_CYC,
                                                               HSEXIT_CYC, WAKEUP_CYC)) + 1
) (
  input  logic           LPTX_CLK,
  input  logic           TxRSt,
  dphy_lp_tx_seq_if.slave lp
);
  import dphy_pkg::*;

  lp_state_t        state;
  lp_state_t        nxt_state;
  logic [2:0]       bit_idx;
  logic [2:0]       nxt_bit;
  logic             stop_hold;
  logic [TMR_W-1:0] tmr_limit;
  logic             tmr_clr;
  logic             tmr_exp;
  logic [1:0]       dec_code;
  logic             dec_oe;

  always_comb begin
    tmr_limit = TMR_W'(LPX_CYC);
    case (state)
      ST_HS_PRPR: tmr_limit = TMR_W'(HSPREP_CYC);
      ST_HS_EXIT: tmr_limit = TMR_W'(HSEXIT_CYC);
      ST_WAKE:    tmr_limit = TMR_W'(WAKEUP_CYC);
      default:    tmr_limit = TMR_W'(LPX_CYC);
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_idx;
    if (!lp.LPTX_EN) begin
      nxt_state = ST_STOP;
    end else begin
      case (state)
        ST_STOP: begin
          // first STOP cycle after HS exit or wake-up ignores requests
          if (!stop_hold) begin
            if (lp.TxRequestHS)
              nxt_state = ST_HS_RQST;
            else if (lp.TxRequestEsc && lp.TxUlpsEsc)
              nxt_state = ST_ESC_RQST;
          end
        end
        ST_HS_RQST: begin
          if (!lp.TxRequestHS)  nxt_state = ST_HS_EXIT;
          else if (tmr_exp)     nxt_state = ST_HS_PRPR;
        end
        ST_HS_PRPR: begin
          if (!lp.TxRequestHS)  nxt_state = ST_HS_EXIT;
          else if (tmr_exp)     nxt_state = ST_HS_GO;
        end
        ST_HS_GO:     if (!lp.TxRequestHS) nxt_state = ST_HS_EXIT;
        ST_HS_EXIT:   if (tmr_exp) nxt_state = ST_STOP;
        ST_ESC_RQST:  if (tmr_exp) nxt_state = ST_ESC_BRDG;
        ST_ESC_BRDG:  if (tmr_exp) nxt_state = ST_ESC_ENTRY;
        ST_ESC_ENTRY: if (tmr_exp) nxt_state = ST_ESC_GO;
        ST_ESC_GO: begin
          if (tmr_exp) begin
            nxt_state = ST_ESC_MARK;
            nxt_bit   = 3'd7;
          end
        end
        ST_ESC_MARK:  if (tmr_exp) nxt_state = ST_ESC_SPACE;
        ST_ESC_SPACE: begin
          if (tmr_exp) begin
            if (bit_idx == 3'd0) begin
              nxt_state = ST_ULPS;
            end else begin
              nxt_state = ST_ESC_MARK;
              nxt_bit   = bit_idx - 3'd1;
            end
          end
        end
        ST_ULPS:      if (lp.TxUlpsExit) nxt_state = ST_WAKE;
        ST_WAKE:      if (tmr_exp) nxt_state = ST_STOP;
        default:      nxt_state = ST_STOP;
      endcase
    end
  end

  assign tmr_clr = !lp.LPTX_EN || (nxt_state != state);

  dphy_lp_timer #(.TMR_W(TMR_W)) u_tmr (
    .LPTX_CLK (LPTX_CLK),
    .TxRSt    (TxRSt),
    .clr      (tmr_clr),
    .limit    (tmr_limit),
    .expire   (tmr_exp)
  );

  always_comb begin
    dec_code = LP11;
    dec_oe   = 1'b1;
    case (nxt_state)
      ST_HS_RQST, ST_ESC_ENTRY:              dec_code = LP01;
      ST_HS_PRPR, ST_ESC_BRDG, ST_ESC_GO,
      ST_ESC_SPACE, ST_ULPS:                 dec_code = LP00;
      ST_ESC_RQST, ST_WAKE:                  dec_code = LP10;
      ST_ESC_MARK:                           dec_code = ESC_CMD[nxt_bit] ? LP10 : LP01;
      ST_HS_GO: begin
        dec_code = LP00;
        dec_oe   = 1'b0;
      end
      default:                               dec_code = LP11;
    endcase
    if (!lp.LPTX_EN) dec_oe = 1'b0;
  end

  always_ff @(posedge LPTX_CLK or negedge TxRSt) begin
    if (!TxRSt) begin
      state            <= ST_STOP;
      bit_idx          <= 3'd0;
      stop_hold        <= 1'b0;
      lp.Dp            <= 1'b1;
      lp.Dn            <= 1'b1;
      lp.LP_OE         <= 1'b0;
      lp.HSTX_EN       <= 1'b0;
      lp.HSCLK_EN      <= 1'b0;
      lp.Stopstate     <= 1'b1;
      lp.UlpsActiveNot <= 1'b1;
    end else begin
      state            <= nxt_state;
      bit_idx          <= nxt_bit;
      stop_hold        <= lp.LPTX_EN && (nxt_state == ST_STOP) &&
                          ((state == ST_HS_EXIT) || (state == ST_WAKE));
      {lp.Dp, lp.Dn}   <= dec_code;
      lp.LP_OE         <= dec_oe;
      lp.HSTX_EN       <= (nxt_state == ST_HS_GO);
      lp.HSCLK_EN      <= (nxt_state == ST_HS_GO);
      lp.Stopstate     <= lp.LPTX_EN && (nxt_state == ST_STOP);
      lp.UlpsActiveNot <= !((nxt_state == ST_ULPS) || (nxt_state == ST_WAKE));
    end
  end

endmodule

// File: tb/tb_dphy_lp_tx_seq.sv
// Randomised bench for dphy_lp_tx_seq: expected line waveforms are built from segment lengths
// (LPX/HSPREP/HSEXIT/WAKEUP) and the escape command bits, then compared cycle by cycle.
module tb_dphy_lp_tx_seq;

  localparam logic [6:0] M_FULL   = 7'h7F;
  localparam logic [6:0] M_NOCODE = 7'h1F;
  localparam logic [7:0] CMD_BYTE = 8'h1E;

  logic LPTX_CLK = 1'b0;
  always #5 LPTX_CLK = ~LPTX_CLK;

  logic TxRSt;
  logic sel;
  logic en, req_hs, req_esc, ulps_esc, ulps_exit;
  int   lpx, hsprep, hsexit, wakeup;
  int   n_chk, n_err;
  logic [6:0] obs;

  dphy_lp_tx_seq_if if_a ();
  dphy_lp_tx_seq_if if_b ();

  assign if_a.LPTX_EN      = sel ? 1'b1 : en;
  assign if_a.TxRequestHS  = sel ? 1'b0 : req_hs;
  assign if_a.TxRequestEsc = sel ? 1'b0 : req_esc;
  assign if_a.TxUlpsEsc    = sel ? 1'b0 : ulps_esc;
  assign if_a.TxUlpsExit   = sel ? 1'b0 : ulps_exit;
  assign if_b.LPTX_EN      = sel ? en        : 1'b1;
  assign if_b.TxRequestHS  = sel ? req_hs    : 1'b0;
  assign if_b.TxRequestEsc = sel ? req_esc   : 1'b0;
  assign if_b.TxUlpsEsc    = sel ? ulps_esc  : 1'b0;
  assign if_b.TxUlpsExit   = sel ? ulps_exit : 1'b0;

  assign obs = sel ? {if_b.Dp, if_b.Dn, if_b.LP_OE, if_b.HSTX_EN, if_b.HSCLK_EN,
                      if_b.Stopstate, if_b.UlpsActiveNot}
                   : {if_a.Dp, if_a.Dn, if_a.LP_OE, if_a.HSTX_EN, if_a.HSCLK_EN,
                      if_a.Stopstate, if_a.UlpsActiveNot};

  dphy_lp_tx_seq #(
    .LPX_CYC(4), .HSPREP_CYC(6), .HSEXIT_CYC(5), .WAKEUP_CYC(10), .ESC_CMD(8'h1E)
  ) u_dut (
    .LPTX_CLK (LPTX_CLK),
    .TxRSt    (TxRSt),
    .lp       (if_a)
  );

  dphy_lp_tx_seq #(
    .LPX_CYC(1), .HSPREP_CYC(1), .HSEXIT_CYC(1), .WAKEUP_CYC(10), .ESC_CMD(8'h1E)
  ) u_dut_min (
    .LPTX_CLK (LPTX_CLK),
    .TxRSt    (TxRSt),
    .lp       (if_b)
  );

  // {Dp,Dn, LP_OE, HSTX_EN, HSCLK_EN, Stopstate, UlpsActiveNot}
  function automatic logic [6:0] ev(input logic [1:0] code, input logic oe, input logic hs,
                                    input logic stop, input logic ulpsn);
    return {code, oe, hs, hs, stop, ulpsn};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input string tag, input logic [6:0] exp, input logic [6:0] mask);
    @(posedge LPTX_CLK);
    #1;
    check_val(tag, 32'(obs & mask), 32'(exp & mask));
  endtask

  task automatic idle_inputs();
    req_hs = 1'b0; req_esc = 1'b0; ulps_esc = 1'b0; ulps_exit = 1'b0;
  endtask

  task automatic noise_all();
    req_hs    = 1'($urandom_range(0, 1));
    req_esc   = 1'($urandom_range(0, 1));
    ulps_esc  = 1'($urandom_range(0, 1));
    ulps_exit = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    TxRSt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      noise_all();
      en = 1'($urandom_range(0, 1));
      tick("reset_vals", ev(2'b11, 1'b0, 1'b0, 1'b1, 1'b1), M_FULL);
    end
    idle_inputs();
    en = 1'b1;
    @(negedge LPTX_CLK);
    TxRSt = 1'b1;
    tick("reset_exit", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
  endtask

  // HS request held for `hold` sampled edges, then dropped
  task automatic hs_burst(input int hold, input bit prio);
    req_hs = 1'b1; req_esc = prio; ulps_esc = prio; ulps_exit = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      if (i <= lpx)
        tick("hs_rqst", ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b1), M_FULL);
      else if (i <= lpx + hsprep)
        tick("hs_prpr", ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b1), M_FULL);
      else
        tick("hs_go", ev(2'b00, 1'b0, 1'b1, 1'b0, 1'b1), M_NOCODE);
      req_esc = 1'($urandom_range(0, 1)); ulps_esc = 1'($urandom_range(0, 1));
      ulps_exit = 1'($urandom_range(0, 1));
    end
    req_hs = 1'b0;
    for (int i = 1; i <= hsexit; i++) begin
      tick("hs_exit", ev(2'b11, 1'b1, 1'b0, 1'b0, 1'b1), M_FULL);
      noise_all();
    end
    tick("hs_stop", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
    noise_all();
    tick("hs_stop_hold", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
    idle_inputs();
    tick("hs_stop_idle", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
  endtask

  // ULPS entry via escape mode; abort_at>0 drops LPTX_EN before that sampled edge
  task automatic esc_ulps(input int abort_at);
    logic [6:0] q[$];
    logic [1:0] entry[4];
    entry[0] = 2'b10; entry[1] = 2'b00; entry[2] = 2'b01; entry[3] = 2'b00;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < lpx; k++) q.push_back(ev(entry[p], 1'b1, 1'b0, 1'b0, 1'b1));
    for (int b = 7; b >= 0; b--) begin
      for (int k = 0; k < lpx; k++)
        q.push_back(ev(CMD_BYTE[b] ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
      for (int k = 0; k < lpx; k++) q.push_back(ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
    end
    req_hs = 1'b0; req_esc = 1'b1; ulps_esc = 1'b1; ulps_exit = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (abort_at == i + 1) begin
        en = 1'b0;
        tick("esc_abort", ev(2'b11, 1'b0, 1'b0, 1'b0, 1'b1), M_NOCODE);
        for (int j = 0; j < 2; j++) begin
          noise_all();
          tick("en_low", ev(2'b11, 1'b0, 1'b0, 1'b0, 1'b1), M_NOCODE);
        end
        idle_inputs();
        en = 1'b1;
        tick("en_resume", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
        return;
      end
      tick("esc_seq", q[i], M_FULL);
      req_esc = 1'($urandom_range(0, 1)); ulps_esc = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < int'($urandom_range(2, 8)); i++) begin
      tick("ulps", ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0), M_FULL);
      req_esc = 1'($urandom_range(0, 1)); ulps_esc = 1'($urandom_range(0, 1));
    end
    ulps_exit = 1'b1;
    for (int i = 1; i <= wakeup; i++) begin
      tick("wake", ev(2'b10, 1'b1, 1'b0, 1'b0, 1'b0), M_FULL);
      noise_all();
    end
    tick("wake_stop", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
    noise_all();
    tick("wake_stop_hold", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
    idle_inputs();
    tick("wake_stop_idle", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
  endtask

  task automatic rst_mid_hs();
    req_hs = 1'b1;
    for (int i = 1; i <= lpx + hsprep + 2; i++) begin
      if (i <= lpx + hsprep) tick("pre_rst", ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b1), M_NOCODE);
      else                   tick("pre_rst_go", ev(2'b00, 1'b0, 1'b1, 1'b0, 1'b1), M_NOCODE);
    end
    TxRSt = 1'b0;
    #1;
    check_val("rst_async", 32'(obs), 32'(ev(2'b11, 1'b0, 1'b0, 1'b1, 1'b1)));
    do_reset();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    sel = 1'b0; en = 1'b1; TxRSt = 1'b0;
    idle_inputs();
    lpx = 4; hsprep = 6; hsexit = 5; wakeup = 10;

    do_reset();
    hs_burst(30, 1'b0);
    hs_burst(lpx + 3, 1'b0);
    hs_burst(int'($urandom_range(12, 25)), 1'b1);
    esc_ulps(0);
    esc_ulps(4 * lpx + 2 * int'($urandom_range(0, 7)) * lpx + 1 + int'($urandom_range(1, 4)));
    rst_mid_hs();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0) esc_ulps(0);
      else hs_burst(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
    end

    sel = 1'b1;
    lpx = 1; hsprep = 1; hsexit = 1; wakeup = 10;
    tick("min_idle", ev(2'b11, 1'b1, 1'b0, 1'b1, 1'b1), M_FULL);
    hs_burst(1, 1'b0);
    hs_burst(2, 1'b0);
    hs_burst(int'($urandom_range(3, 12)), 1'b1);
    esc_ulps(0);
    esc_ulps(4 + 2 * int'($urandom_range(0, 7)) + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
